// File: rtl/tl_a_channel_queue.sv
// Ready/valid FIFO for one TileLink-UL A channel with a registered dequeue side.
// It has no combinational path from enq to deq, and it reports its occupancy for performance monitors.
module tl_a_channel_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned SRC_W = 1,
    parameter int unsigned CNT_W = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [2:0]        enq_opcode,
    input  logic [2:0]        enq_param,
    input  logic [1:0]        enq_size,
    input  logic [SRC_W-1:0]  enq_source,
    input  logic [31:0]       enq_address,
    input  logic [3:0]        enq_mask,
    input  logic [31:0]       enq_data,
    input  logic              enq_corrupt,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [2:0]        deq_opcode,
    output logic [2:0]        deq_param,
    output logic [1:0]        deq_size,
    output logic [SRC_W-1:0]  deq_source,
    output logic [31:0]       deq_address,
    output logic [3:0]        deq_mask,
    output logic [31:0]       deq_data,
    output logic              deq_corrupt,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned ENTRY_W = 77 + SRC_W;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [ENTRY_W-1:0] enq_entry;
    logic [ENTRY_W-1:0] head;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               full;
    logic               empty;
    logic               enq_fire;
    logic               deq_fire;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign enq_fire  = enq_valid && enq_ready;
    assign deq_fire  = deq_valid && deq_ready;

    assign enq_entry = {enq_opcode, enq_param, enq_size, enq_source,
                        enq_address, enq_mask, enq_data, enq_corrupt};
    assign head      = mem[rd_ptr];
    assign {deq_opcode, deq_param, deq_size, deq_source,
            deq_address, deq_mask, deq_data, deq_corrupt} = head;

    // Storage is cleared on reset so that the idle head reads as zero instead of X.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (enq_fire) begin
                mem[wr_ptr] <= enq_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_a_channel_queue.sv
// Self-checking bench for tl_a_channel_queue.
// A queue-based reference model is checked on every cycle, alongside directed literal checks and a randomized phase.
module tb_tl_a_channel_queue;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned SRC_W = 1;
    localparam int unsigned CNT_W = 2;

    typedef logic [76+SRC_W:0] ent_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              enq_valid = 1'b1;
    logic              enq_ready;
    logic [2:0]        enq_opcode = '0;
    logic [2:0]        enq_param = '0;
    logic [1:0]        enq_size = '0;
    logic [SRC_W-1:0]  enq_source = '0;
    logic [31:0]       enq_address = 32'h1234_5678;
    logic [3:0]        enq_mask = '0;
    logic [31:0]       enq_data = '0;
    logic              enq_corrupt = 1'b0;
    logic              deq_valid;
    logic              deq_ready = 1'b0;
    logic [2:0]        deq_opcode;
    logic [2:0]        deq_param;
    logic [1:0]        deq_size;
    logic [SRC_W-1:0]  deq_source;
    logic [31:0]       deq_address;
    logic [3:0]        deq_mask;
    logic [31:0]       deq_data;
    logic              deq_corrupt;
    logic [CNT_W-1:0]  count;

    int total = 0;
    int bad   = 0;
    ent_t q[$];

    tl_a_channel_queue #(.DEPTH(DEPTH), .SRC_W(SRC_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset_n(reset_n),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_opcode(enq_opcode), .enq_param(enq_param), .enq_size(enq_size),
        .enq_source(enq_source), .enq_address(enq_address), .enq_mask(enq_mask),
        .enq_data(enq_data), .enq_corrupt(enq_corrupt),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_opcode(deq_opcode), .deq_param(deq_param), .deq_size(deq_size),
        .deq_source(deq_source), .deq_address(deq_address), .deq_mask(deq_mask),
        .deq_data(deq_data), .deq_corrupt(deq_corrupt),
        .count(count)
    );

    always #5 clock = ~clock;

    function automatic ent_t enq_pack();
        return {enq_opcode, enq_param, enq_size, enq_source,
                enq_address, enq_mask, enq_data, enq_corrupt};
    endfunction

    function automatic ent_t deq_pack();
        return {deq_opcode, deq_param, deq_size, deq_source,
                deq_address, deq_mask, deq_data, deq_corrupt};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an ideal bounded queue that is sampled on the same edge as the DUT.
    always @(posedge clock or negedge reset_n) begin : model
        bit   e;
        bit   d;
        ent_t nw;
        if (!reset_n) begin
            q.delete();
        end else begin
            e  = enq_valid && (q.size() < DEPTH);
            d  = deq_ready && (q.size() != 0);
            nw = enq_pack();
            if (d) void'(q.pop_front());
            if (e) q.push_back(nw);
        end
    end

    always @(negedge clock) begin
        chk("enq_ready", 128'(enq_ready), 128'(q.size() < DEPTH));
        chk("deq_valid", 128'(deq_valid), 128'(q.size() != 0));
        chk("count", 128'(count), 128'(q.size()));
        if (q.size() != 0) chk("payload", 128'(deq_pack()), 128'(q[0]));
    end

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        // 1: reset held with enq_valid high
        repeat (3) cyc();
        chk("rst_enq_ready", 128'(enq_ready), 128'(1));
        chk("rst_deq_valid", 128'(deq_valid), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_deq_address", 128'(deq_address), 128'(0));
        reset_n   = 1'b1;
        enq_valid = 1'b0;
        cyc();
        chk("rst_nothing_enqueued", 128'(count), 128'(0));

        // 2: single beat with deq_ready held high
        enq_opcode = 3'd4; enq_address = 32'h8000_0010; enq_mask = 4'hF;
        enq_data = 32'h0BAD_F00D; enq_valid = 1'b1; deq_ready = 1'b1;
        cyc();
        enq_valid = 1'b0;
        chk("single_valid", 128'(deq_valid), 128'(1));
        chk("single_count1", 128'(count), 128'(1));
        chk("single_addr", 128'(deq_address), 128'(32'h8000_0010));
        chk("single_opcode", 128'(deq_opcode), 128'(4));
        chk("single_mask", 128'(deq_mask), 128'(4'hF));
        cyc();
        chk("single_count0", 128'(count), 128'(0));

        // 3: fill, verify a third beat is held off, then drain in order
        deq_ready = 1'b0; enq_valid = 1'b1; enq_source = 1'b0;
        cyc();
        enq_source = 1'b1;
        cyc();
        chk("fill_count", 128'(count), 128'(2));
        chk("fill_enq_ready", 128'(enq_ready), 128'(0));
        enq_source = 1'b0; enq_address = 32'h0000_DEAD;
        cyc();
        chk("held_count", 128'(count), 128'(2));
        enq_valid = 1'b0; deq_ready = 1'b1;
        chk("drain_src0", 128'(deq_source), 128'(0));
        cyc();
        chk("drain_src1", 128'(deq_source), 128'(1));
        cyc();
        chk("drain_empty", 128'(count), 128'(0));

        // 4: steady enq+deq at count=1 with incrementing data
        deq_ready = 1'b0; enq_valid = 1'b1; enq_data = 32'd100;
        cyc();
        deq_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            enq_data = 32'(i);
            cyc();
            chk("stream_count", 128'(count), 128'(1));
            chk("stream_data", 128'(deq_data), 128'(i));
        end
        enq_valid = 1'b0;
        cyc();

        // 5: full with deq_ready and enq_valid both high
        deq_ready = 1'b0; enq_valid = 1'b1;
        cyc(); cyc();
        chk("full_count", 128'(count), 128'(2));
        deq_ready = 1'b1;
        cyc();
        chk("full_c0_count", 128'(count), 128'(1));
        chk("full_c1_enq_ready", 128'(enq_ready), 128'(1));
        cyc();
        chk("full_c1_count", 128'(count), 128'(1));
        enq_valid = 1'b0;
        cyc(); cyc();

        // 6: asynchronous reset pulse while holding two entries
        deq_ready = 1'b0; enq_valid = 1'b1;
        cyc(); cyc();
        enq_valid = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("async_count", 128'(count), 128'(0));
        chk("async_deq_valid", 128'(deq_valid), 128'(0));
        #1 reset_n = 1'b1;
        @(negedge clock);
        enq_data = 32'hCAFE_F00D; enq_valid = 1'b1;
        cyc();
        enq_valid = 1'b0;
        chk("after_rst_valid", 128'(deq_valid), 128'(1));
        chk("after_rst_data", 128'(deq_data), 128'(32'hCAFE_F00D));
        deq_ready = 1'b1;
        cyc();

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            enq_valid   = ($urandom_range(0, 3) != 0);
            deq_ready   = ($urandom_range(0, 2) != 0);
            enq_opcode  = 3'($urandom);
            enq_param   = 3'($urandom);
            enq_size    = 2'($urandom);
            enq_source  = SRC_W'($urandom);
            enq_address = $urandom;
            enq_mask    = 4'($urandom);
            enq_data    = $urandom;
            enq_corrupt = 1'($urandom);
            cyc();
        end
        enq_valid = 1'b0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
